// File: rtl/i2c_target_regfile_pkg.sv
// Shared types and constants for the I2C target register file.
// Optional glitch filter is enabled by defining I2C_TARGET_FILTER_EN.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8
  } i2c_tgt_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // 2-of-3 vote used by the optional glitch filter
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_target_regfile_bus_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// Defining I2C_TARGET_FILTER_EN inserts a 3-sample majority filter (+2 cycles).
module i2c_bus_sync
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Idle bus is high, so all stages reset to 1 to avoid false edges.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;
  logic       scl_hist_q, sda_hist_q;

  // Two-flop synchroniser on both pads
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  logic [1:0] scl_tap_q, sda_tap_q;
  logic       scl_filt_q, sda_filt_q;

  // Majority over three consecutive samples; a 1-cycle pulse never wins the vote
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_tap_q  <= 2'b11;
      sda_tap_q  <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_tap_q  <= {scl_tap_q[0], scl_sync_q[1]};
      sda_tap_q  <= {sda_tap_q[0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_sync_q[1], scl_tap_q[0], scl_tap_q[1]);
      sda_filt_q <= maj3(sda_sync_q[1], sda_tap_q[0], sda_tap_q[1]);
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  // History flop: previous level for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_f;
      sda_hist_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_hist_q;
  assign scl_fall  = ~scl_f & scl_hist_q;
  assign start_det = scl_f & scl_hist_q & sda_hist_q & ~sda_f;
  assign stop_det  = scl_f & scl_hist_q & ~sda_hist_q & sda_f;
  assign sda_s     = sda_f;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing 8-bit register bank and a host port.
// Handshake: none on the host port -- host_we writes reg[host_addr] on every
// clock it is high; host_rdata is reg[host_addr] combinationally.
// Build option: I2C_TARGET_FILTER_EN (glitch filter in i2c_bus_sync).
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         NUM_REGS    = 16,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           scl_i,
  input  logic           sda_i,
  output logic           sda_oe,
  input  logic           host_we,
  input  logic [PW-1:0]  host_addr,
  input  logic [7:0]     host_wdata,
  output logic [7:0]     host_rdata,
  output logic           wr_stb,
  output logic [PW-1:0]  wr_idx,
  output logic           busy,
  output i2c_tgt_state_e dbg_state_o
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_e state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           sda_oe_q, sda_oe_d;
  logic           busy_q, busy_d;
  logic           ack_on_q, ack_on_d;
  logic           rw_q, rw_d;
  logic           wr_stb_q, wr_stb_d;
  logic [PW-1:0]  wr_idx_q, wr_idx_d;
  logic           i2c_we;
  logic [7:0]     byte_in;
  logic [PW-1:0]  ptr_inc;
  logic [7:0]     regs_q [NUM_REGS];

  assign byte_in = {shift_q[6:0], sda_s};
  assign ptr_inc = ptr_q + PW'(1);

  // Protocol FSM: next state, shifter, pointer and SDA drive
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    ack_on_d  = ack_on_q;
    rw_d      = rw_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    i2c_we    = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_on_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      ack_on_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ADDR) begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_in[PW-1:0];
                state_d = PTR_ACK;
              end else begin
                i2c_we   = 1'b1;
                wr_stb_d = 1'b1;
                wr_idx_d = ptr_q;
                ptr_d    = ptr_inc;
                state_d  = WDATA_ACK;
              end
            end
          end
        end
        // First fall drives ACK low; the ACK-clock fall releases it and moves on
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
              sda_oe_d = ~ACK;
            end else begin
              ack_on_d  = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = RDATA;
              end else if (state_q == ADDR_ACK && rw_q == RW_WRITE) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = RDATA_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d    = ptr_inc;
              shift_d  = regs_q[ptr_inc];
              ack_on_d = 1'b1;
            end
          end else if (scl_fall && ack_on_q) begin
            ack_on_d  = 1'b0;
            sda_oe_d  = ~shift_q[7];
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and datapath state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_on_q  <= 1'b0;
      rw_q      <= RW_WRITE;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      ack_on_q  <= ack_on_d;
      rw_q      <= rw_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  // Register bank: I2C write beats a same-index host write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we && (ptr_q == PW'(i))) regs_q[i] <= byte_in;
        else if (host_we && (host_addr == PW'(i))) regs_q[i] <= host_wdata;
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign wr_stb      = wr_stb_q;
  assign wr_idx      = wr_idx_q;
  assign host_rdata  = regs_q[host_addr];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bus master tasks, array reference model,
// wr_idx scoreboard, directed scenarios followed by randomized traffic.
module tb_i2c_target_regfile;
  import i2c_target_pkg::*;

  localparam int NREGS = 16;
  localparam int PW    = 4;
  localparam int Q     = 60;  // quarter SCL period = 6 clk

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic           scl_m = 1'b1;
  logic           sda_m = 1'b1;
  logic           sda_oe;
  logic           sda_line;
  logic           host_we = 1'b0;
  logic [PW-1:0]  host_addr = '0;
  logic [7:0]     host_wdata = 8'h00;
  logic [7:0]     host_rdata;
  logic           wr_stb;
  logic [PW-1:0]  wr_idx;
  logic           busy;
  i2c_tgt_state_e dbg_state;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regfile dut (
    .clk         (clk),
    .rstn        (rstn),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_oe      (sda_oe),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .wr_stb      (wr_stb),
    .wr_idx      (wr_idx),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int            assert_cnt = 0;
  int            fail_cnt   = 0;
  logic [7:0]    mregs [NREGS];
  int            mptr = 0;
  logic [PW-1:0] exp_q [$];
  logic [7:0]    tx_q [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next index the model predicted
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      logic [PW-1:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      assert_cnt++;
      assert (wr_idx === e) else begin
        fail_cnt++;
        $error("FAIL wr_idx: observed %h expected %h", wr_idx, e);
      end
    end
  end

  // ---------------- bus master driver tasks ----------------
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      host_addr = PW'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), host_rdata, mregs[i]);
    end
    @(negedge clk);
  endtask

  task automatic host_write(input logic [PW-1:0] idx, input logic [7:0] d);
    @(negedge clk);
    host_addr = idx; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    mregs[idx] = d;
  endtask

  // Address + pointer + all bytes of tx_q, ACK checked on every byte
  task automatic do_write(input logic [7:0] ptr_byte, input string tag);
    logic a;
    bus_start();
    write_byte({7'h2A, RW_WRITE}, a);
    check({tag, "_addr_ack"}, a, ACK);
    check({tag, "_busy"}, busy, 1'b1);
    write_byte(ptr_byte, a);
    check({tag, "_ptr_ack"}, a, ACK);
    mptr = int'(ptr_byte) % NREGS;
    for (int i = 0; i < tx_q.size(); i++) begin
      exp_q.push_back(PW'(mptr));
      mregs[mptr] = tx_q[i];
      mptr = (mptr + 1) % NREGS;
      write_byte(tx_q[i], a);
      check($sformatf("%s_data%0d_ack", tag, i), a, ACK);
    end
    bus_stop();
  endtask

  // Pointer write, repeated START, read n bytes (ACK all but last)
  task automatic do_read(input logic [7:0] ptr_byte, input int n, input string tag);
    logic a;
    logic [7:0] d;
    bus_start();
    write_byte({7'h2A, RW_WRITE}, a);
    check({tag, "_addr_ack"}, a, ACK);
    write_byte(ptr_byte, a);
    check({tag, "_ptr_ack"}, a, ACK);
    mptr = int'(ptr_byte) % NREGS;
    bus_start();
    write_byte({7'h2A, RW_READ}, a);
    check({tag, "_raddr_ack"}, a, ACK);
    for (int k = 0; k < n; k++) begin
      read_byte(d, (k == n - 1) ? NACK : ACK);
      check($sformatf("%s_rd%0d", tag, k), d, mregs[mptr]);
      if (k != n - 1) mptr = (mptr + 1) % NREGS;
    end
    check({tag, "_busy_after_nack"}, busy, 1'b0);
    bus_stop();
  endtask

  // Single-byte write with host_we held to haddr up to the I2C write cycle
  task automatic coll_write(input logic [7:0] ptr_byte, input logic [7:0] d,
                            input logic [PW-1:0] haddr, input logic [7:0] hdata,
                            input string tag);
    logic a;
    logic seen;
    bus_start();
    write_byte({7'h2A, RW_WRITE}, a);
    check({tag, "_addr_ack"}, a, ACK);
    write_byte(ptr_byte, a);
    check({tag, "_ptr_ack"}, a, ACK);
    mptr = int'(ptr_byte) % NREGS;
    exp_q.push_back(PW'(mptr));
    for (int i = 7; i >= 1; i--) write_bit(d[i]);
    host_addr = haddr; host_wdata = hdata; host_we = 1'b1;
    sda_m = d[0]; #Q; scl_m = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (wr_stb === 1'b1) seen = 1'b1;
    end
    host_we = 1'b0;
    check({tag, "_stb_seen"}, seen, 1'b1);
    #Q; scl_m = 1'b0; #Q;
    read_bit(a);
    check({tag, "_data_ack"}, a, ACK);
    bus_stop();
    mregs[haddr] = hdata;
    mregs[mptr] = d;
    mptr = (mptr + 1) % NREGS;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic a;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_idx", wr_idx, 8'h00);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check_all_regs("rst");

    // 1: basic write with auto-increment
    tx_q = '{8'hA5, 8'h5A};
    do_write(8'h03, "t1");
    check_all_regs("t1");

    // 2: pointer wrap on write
    tx_q = '{8'h11, 8'h22};
    do_write(8'h0F, "t2");
    check_all_regs("t2");

    // 3: repeated-START read with ACK then NACK; also read across the wrap
    do_read(8'h03, 2, "t3");
    do_read(8'h0F, 2, "t3w");

    // 4: wrong address is not acknowledged and changes nothing
    bus_start();
    write_byte({7'h2B, RW_WRITE}, a);
    check("t4_nack", a, NACK);
    check("t4_busy", busy, 1'b0);
    write_byte(8'hFF, a);
    bus_stop();
    check_all_regs("t4");

    // 5: STOP after 4 data bits aborts the byte
    bus_start();
    write_byte({7'h2A, RW_WRITE}, a);
    check("t5_addr_ack", a, ACK);
    write_byte(8'h05, a);
    check("t5_ptr_ack", a, ACK);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    bus_stop();
    check("t5_sda_oe", sda_oe, 1'b0);
    check("t5_state", dbg_state, IDLE);
    check("t5_busy", busy, 1'b0);
    check_all_regs("t5");
    tx_q = '{8'h77};
    do_write(8'h05, "t5b");
    check_all_regs("t5b");

    // 6: same-register collision (I2C wins), different-register (both land)
    coll_write(8'h04, 8'h7E, 4'd4, 8'hC3, "t6same");
    check_all_regs("t6same");
    coll_write(8'h04, 8'h3D, 4'd9, 8'h96, "t6diff");
    check_all_regs("t6diff");

    // Random traffic against the model
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(4, 1);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(255, 0)));
      do_write(8'($urandom_range(255, 0)), $sformatf("rw%0d", it));
      if ($urandom_range(1, 0) == 1)
        host_write(PW'($urandom_range(NREGS - 1, 0)), 8'($urandom_range(255, 0)));
      do_read(8'($urandom_range(255, 0)), $urandom_range(4, 1), $sformatf("rr%0d", it));
    end
    check_all_regs("rand");

    // 6b: reset in the middle of a read while the target pulls SDA low
    tx_q = '{8'h12};
    do_write(8'h06, "t6r");
    bus_start();
    write_byte({7'h2A, RW_WRITE}, a);
    write_byte(8'h06, a);
    bus_start();
    write_byte({7'h2A, RW_READ}, a);
    check("t6r_raddr_ack", a, ACK);
    check("t6r_drive_msb", sda_oe, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    check("t6r_sda_oe_async", sda_oe, 1'b0);
    check("t6r_busy_async", busy, 1'b0);
    @(negedge clk);
    scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    #Q;
    rstn = 1'b1;
    #Q;
    check("t6r_state", dbg_state, IDLE);
    check_all_regs("t6r_rst");
    tx_q = '{8'hE1, 8'h1E};
    do_write(8'h0A, "post");
    do_read(8'h0A, 2, "postr");

    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
